// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RISC-V pipeline types and constants
package rv_pkg;

  localparam int RV_XLEN       = 32;
  localparam int RV_REG_ADDR_W = 5;
  localparam int REG_X0        = 0;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9
  } alu_operations_e;

  typedef struct packed {
    alu_operations_e            alu_ctrl;
    logic [RV_REG_ADDR_W-1:0]   rs1_addr;
    logic [RV_REG_ADDR_W-1:0]   rs2_addr;
    logic [RV_XLEN-1:0]         rs1_data;
    logic [RV_XLEN-1:0]         rs2_data;
    logic [RV_XLEN-1:0]         imm;
    logic                       use_imm;
    logic [RV_REG_ADDR_W-1:0]   rd;
    logic                       reg_write;
  } id_ex_bundle_t;

endpackage

// File: rtl/rv_id_ex_stage_if.sv
// rtl/rv_id_ex_stage_if.sv - decode/execute/forwarding signal bundle for the ID/EX register
interface rv_id_ex_stage_if #(
  parameter int XLEN       = rv_pkg::RV_XLEN,
  parameter int REG_ADDR_W = rv_pkg::RV_REG_ADDR_W
) ();
  import rv_pkg::*;

  logic                  flush_i;
  logic                  id_valid_i;
  logic                  id_ready_o;
  alu_operations_e       id_alu_ctrl_i;
  logic [REG_ADDR_W-1:0] id_rs1_addr_i;
  logic [REG_ADDR_W-1:0] id_rs2_addr_i;
  logic [XLEN-1:0]       id_rs1_data_i;
  logic [XLEN-1:0]       id_rs2_data_i;
  logic [XLEN-1:0]       id_imm_i;
  logic                  id_use_imm_i;
  logic [REG_ADDR_W-1:0] id_rd_addr_i;
  logic                  id_reg_write_i;

  logic                  ex_valid_o;
  logic                  ex_ready_i;
  alu_operations_e       alu_ctrl_o;
  logic [XLEN-1:0]       operand_a_o;
  logic [XLEN-1:0]       operand_b_o;
  logic [XLEN-1:0]       store_data_o;
  logic [REG_ADDR_W-1:0] rd_addr_o;
  logic                  reg_write_o;

  logic                  mem_fwd_valid_i;
  logic [REG_ADDR_W-1:0] mem_fwd_rd_i;
  logic [XLEN-1:0]       mem_fwd_data_i;
  logic                  wb_fwd_valid_i;
  logic [REG_ADDR_W-1:0] wb_fwd_rd_i;
  logic [XLEN-1:0]       wb_fwd_data_i;

  modport slave (
    input  flush_i, id_valid_i, id_alu_ctrl_i, id_rs1_addr_i, id_rs2_addr_i,
           id_rs1_data_i, id_rs2_data_i, id_imm_i, id_use_imm_i, id_rd_addr_i,
           id_reg_write_i, ex_ready_i,
           mem_fwd_valid_i, mem_fwd_rd_i, mem_fwd_data_i,
           wb_fwd_valid_i, wb_fwd_rd_i, wb_fwd_data_i,
    output id_ready_o, ex_valid_o, alu_ctrl_o, operand_a_o, operand_b_o,
           store_data_o, rd_addr_o, reg_write_o
  );

  modport master (
    output flush_i, id_valid_i, id_alu_ctrl_i, id_rs1_addr_i, id_rs2_addr_i,
           id_rs1_data_i, id_rs2_data_i, id_imm_i, id_use_imm_i, id_rd_addr_i,
           id_reg_write_i, ex_ready_i,
           mem_fwd_valid_i, mem_fwd_rd_i, mem_fwd_data_i,
           wb_fwd_valid_i, wb_fwd_rd_i, wb_fwd_data_i,
    input  id_ready_o, ex_valid_o, alu_ctrl_o, operand_a_o, operand_b_o,
           store_data_o, rd_addr_o, reg_write_o
  );

endinterface

// File: rtl/rv_fwd_mux.sv
// rtl/rv_fwd_mux.sv - per-source operand forwarding select (MEM over WB over register file)
module rv_fwd_mux
  import rv_pkg::*;
#(
  parameter int XLEN       = RV_XLEN,
  parameter int REG_ADDR_W = RV_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] i_src_addr,
  input  logic [XLEN-1:0]       i_src_data,
  input  logic                  i_mem_valid,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic [XLEN-1:0]       i_mem_data,
  input  logic                  i_wb_valid,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic [XLEN-1:0]       i_wb_data,
  output logic [XLEN-1:0]       o_data
);

  logic w_src_nz;
  logic w_mem_hit;
  logic w_wb_hit;

  // x0 is hardwired zero, so a producer "writing" it must never be forwarded.
  assign w_src_nz  = (i_src_addr != REG_ADDR_W'(REG_X0));
  assign w_mem_hit = i_mem_valid && (i_mem_rd == i_src_addr) && w_src_nz;
  assign w_wb_hit  = i_wb_valid  && (i_wb_rd  == i_src_addr) && w_src_nz;

  always_comb begin
    o_data = i_src_data;
    if (w_mem_hit) begin
      o_data = i_mem_data;
    end else if (w_wb_hit) begin
      o_data = i_wb_data;
    end
  end

endmodule

// File: rtl/rv_id_ex_stage.sv
// rtl/rv_id_ex_stage.sv - ID/EX pipeline register with valid/ready handshake, flush and operand forwarding
module rv_id_ex_stage
  import rv_pkg::*;
#(
  parameter int XLEN       = RV_XLEN,
  parameter int REG_ADDR_W = RV_REG_ADDR_W
) (
  input logic             clk_i,
  input logic             rst_i,
  rv_id_ex_stage_if.slave bus
);

  id_ex_bundle_t   r_bundle;
  logic            r_valid;

  id_ex_bundle_t   w_id_bundle;
  logic            w_ready;
  logic            w_accept;
  logic            w_drain;
  logic [XLEN-1:0] w_rs1_fwd;
  logic [XLEN-1:0] w_rs2_fwd;

  assign w_ready  = !r_valid || bus.ex_ready_i;
  assign w_accept = bus.id_valid_i && w_ready && !bus.flush_i;
  assign w_drain  = r_valid && bus.ex_ready_i;

  assign w_id_bundle = '{
    alu_ctrl:  bus.id_alu_ctrl_i,
    rs1_addr:  bus.id_rs1_addr_i,
    rs2_addr:  bus.id_rs2_addr_i,
    rs1_data:  bus.id_rs1_data_i,
    rs2_data:  bus.id_rs2_data_i,
    imm:       bus.id_imm_i,
    use_imm:   bus.id_use_imm_i,
    rd:        bus.id_rd_addr_i,
    reg_write: bus.id_reg_write_i
  };

  // While stalled, fold forwarded values back into the stored operands so a
  // producer that leaves MEM/WB during the stall is not lost.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid  <= 1'b0;
      r_bundle <= '0;
    end else if (bus.flush_i) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_bundle <= w_id_bundle;
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end else if (r_valid) begin
      r_bundle.rs1_data <= w_rs1_fwd;
      r_bundle.rs2_data <= w_rs2_fwd;
    end
  end

  rv_fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .i_src_addr  (r_bundle.rs1_addr),
    .i_src_data  (r_bundle.rs1_data),
    .i_mem_valid (bus.mem_fwd_valid_i),
    .i_mem_rd    (bus.mem_fwd_rd_i),
    .i_mem_data  (bus.mem_fwd_data_i),
    .i_wb_valid  (bus.wb_fwd_valid_i),
    .i_wb_rd     (bus.wb_fwd_rd_i),
    .i_wb_data   (bus.wb_fwd_data_i),
    .o_data      (w_rs1_fwd)
  );

  rv_fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .i_src_addr  (r_bundle.rs2_addr),
    .i_src_data  (r_bundle.rs2_data),
    .i_mem_valid (bus.mem_fwd_valid_i),
    .i_mem_rd    (bus.mem_fwd_rd_i),
    .i_mem_data  (bus.mem_fwd_data_i),
    .i_wb_valid  (bus.wb_fwd_valid_i),
    .i_wb_rd     (bus.wb_fwd_rd_i),
    .i_wb_data   (bus.wb_fwd_data_i),
    .o_data      (w_rs2_fwd)
  );

  assign bus.id_ready_o   = w_ready;
  assign bus.ex_valid_o   = r_valid;
  assign bus.alu_ctrl_o   = r_bundle.alu_ctrl;
  assign bus.operand_a_o  = w_rs1_fwd;
  assign bus.operand_b_o  = r_bundle.use_imm ? r_bundle.imm : w_rs2_fwd;
  assign bus.store_data_o = w_rs2_fwd;
  assign bus.rd_addr_o    = r_bundle.rd;
  assign bus.reg_write_o  = r_bundle.reg_write && r_valid;

endmodule

// File: tb/tb_rv_id_ex_stage.sv
// tb/tb_rv_id_ex_stage.sv - directed vector bench for rv_id_ex_stage
module tb_rv_id_ex_stage;
  import rv_pkg::*;

  typedef struct {
    logic vld; logic rdy; logic fl; alu_operations_e op;
    logic [4:0] rs1; logic [4:0] rs2; logic [31:0] d1; logic [31:0] d2;
    logic [31:0] imm; logic ui; logic [4:0] rd; logic rw;
    logic mv; logic [4:0] mrd; logic [31:0] md;
    logic wv; logic [4:0] wrd; logic [31:0] wd;
    logic e_vld; logic e_rdy; logic e_rw; logic chk; alu_operations_e e_op;
    logic [31:0] e_a; logic [31:0] e_b; logic [31:0] e_sd; logic [4:0] e_rd;
  } vec_t;

  localparam int NVEC = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;
  vec_t vecs [NVEC];
  vec_t idle;

  rv_id_ex_stage_if bus ();

  rv_id_ex_stage dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    bus.id_valid_i      = v.vld;
    bus.ex_ready_i      = v.rdy;
    bus.flush_i         = v.fl;
    bus.id_alu_ctrl_i   = v.op;
    bus.id_rs1_addr_i   = v.rs1;
    bus.id_rs2_addr_i   = v.rs2;
    bus.id_rs1_data_i   = v.d1;
    bus.id_rs2_data_i   = v.d2;
    bus.id_imm_i        = v.imm;
    bus.id_use_imm_i    = v.ui;
    bus.id_rd_addr_i    = v.rd;
    bus.id_reg_write_i  = v.rw;
    bus.mem_fwd_valid_i = v.mv;
    bus.mem_fwd_rd_i    = v.mrd;
    bus.mem_fwd_data_i  = v.md;
    bus.wb_fwd_valid_i  = v.wv;
    bus.wb_fwd_rd_i     = v.wrd;
    bus.wb_fwd_data_i   = v.wd;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    chk({tag, " ex_valid"},  32'(bus.ex_valid_o),  32'(v.e_vld));
    chk({tag, " id_ready"},  32'(bus.id_ready_o),  32'(v.e_rdy));
    chk({tag, " reg_write"}, 32'(bus.reg_write_o), 32'(v.e_rw));
    if (v.chk) begin
      chk({tag, " alu_ctrl"},   32'(bus.alu_ctrl_o), 32'(v.e_op));
      chk({tag, " operand_a"},  bus.operand_a_o,     v.e_a);
      chk({tag, " operand_b"},  bus.operand_b_o,     v.e_b);
      chk({tag, " store_data"}, bus.store_data_o,    v.e_sd);
      chk({tag, " rd_addr"},    32'(bus.rd_addr_o),  32'(v.e_rd));
    end
  endtask

  initial begin
    idle = '{1'b0,1'b0,1'b0,OP_ADD,5'd0,5'd0,32'h0,32'h0,32'h0,1'b0,5'd0,1'b0, 1'b0,5'd0,32'h0,1'b0,5'd0,32'h0, 1'b0,1'b1,1'b0,1'b0,OP_ADD,32'h0,32'h0,32'h0,5'd0};

    // vld rdy fl op rs1 rs2 d1 d2 imm ui rd rw | mv mrd md wv wrd wd | e_vld e_rdy e_rw chk e_op e_a e_b e_sd e_rd
    vecs[0]  = '{1'b1,1'b0,1'b0,OP_ADD,5'd1,5'd2,32'h5,32'h7,32'h0,1'b0,5'd3,1'b1, 1'b0,5'd0,32'h0,1'b0,5'd0,32'h0, 1'b1,1'b0,1'b1,1'b1,OP_ADD,32'h5,32'h7,32'h7,5'd3};
    vecs[1]  = '{1'b0,1'b0,1'b0,OP_ADD,5'd0,5'd0,32'h0,32'h0,32'h0,1'b0,5'd0,1'b0, 1'b1,5'd1,32'h11,1'b0,5'd0,32'h0, 1'b1,1'b0,1'b1,1'b1,OP_ADD,32'h11,32'h7,32'h7,5'd3};
    vecs[2]  = '{1'b0,1'b0,1'b0,OP_ADD,5'd0,5'd0,32'h0,32'h0,32'h0,1'b0,5'd0,1'b0, 1'b0,5'd0,32'h0,1'b0,5'd0,32'h0, 1'b1,1'b0,1'b1,1'b1,OP_ADD,32'h11,32'h7,32'h7,5'd3};
    vecs[3]  = '{1'b0,1'b1,1'b0,OP_ADD,5'd0,5'd0,32'h0,32'h0,32'h0,1'b0,5'd0,1'b0, 1'b0,5'd0,32'h0,1'b0,5'd0,32'h0, 1'b0,1'b1,1'b0,1'b0,OP_ADD,32'h0,32'h0,32'h0,5'd0};
    vecs[4]  = '{1'b1,1'b0,1'b0,OP_XOR,5'd3,5'd5,32'h33,32'h55,32'h100,1'b1,5'd6,1'b1, 1'b1,5'd3,32'hAA,1'b1,5'd3,32'hBB, 1'b1,1'b0,1'b1,1'b1,OP_XOR,32'hAA,32'h100,32'h55,5'd6};
    vecs[5]  = '{1'b0,1'b0,1'b0,OP_ADD,5'd0,5'd0,32'h0,32'h0,32'h0,1'b0,5'd0,1'b0, 1'b0,5'd3,32'hAA,1'b1,5'd3,32'hBB, 1'b1,1'b0,1'b1,1'b1,OP_XOR,32'hBB,32'h100,32'h55,5'd6};
    vecs[6]  = '{1'b1,1'b1,1'b0,OP_OR,5'd0,5'd0,32'h77,32'h88,32'h0,1'b0,5'd8,1'b1, 1'b1,5'd0,32'hAA,1'b1,5'd0,32'hBB, 1'b1,1'b1,1'b1,1'b1,OP_OR,32'h77,32'h88,32'h88,5'd8};
    vecs[7]  = '{1'b1,1'b1,1'b0,OP_AND,5'd1,5'd4,32'h1,32'h40,32'h0,1'b0,5'd7,1'b1, 1'b0,5'd0,32'h0,1'b0,5'd0,32'h0, 1'b1,1'b1,1'b1,1'b1,OP_AND,32'h1,32'h40,32'h40,5'd7};
    vecs[8]  = '{1'b0,1'b0,1'b0,OP_ADD,5'd0,5'd0,32'h0,32'h0,32'h0,1'b0,5'd0,1'b0, 1'b0,5'd0,32'h0,1'b1,5'd4,32'h1234, 1'b1,1'b0,1'b1,1'b1,OP_AND,32'h1,32'h1234,32'h1234,5'd7};
    vecs[9]  = '{1'b0,1'b0,1'b0,OP_ADD,5'd0,5'd0,32'h0,32'h0,32'h0,1'b0,5'd0,1'b0, 1'b0,5'd0,32'h0,1'b0,5'd0,32'h0, 1'b1,1'b0,1'b1,1'b1,OP_AND,32'h1,32'h1234,32'h1234,5'd7};
    vecs[10] = '{1'b1,1'b0,1'b1,OP_SLT,5'd9,5'd9,32'h99,32'h99,32'h0,1'b0,5'd9,1'b1, 1'b0,5'd0,32'h0,1'b0,5'd0,32'h0, 1'b0,1'b1,1'b0,1'b0,OP_ADD,32'h0,32'h0,32'h0,5'd0};
    vecs[11] = '{1'b0,1'b0,1'b0,OP_ADD,5'd0,5'd0,32'h0,32'h0,32'h0,1'b0,5'd0,1'b0, 1'b0,5'd0,32'h0,1'b0,5'd0,32'h0, 1'b0,1'b1,1'b0,1'b0,OP_ADD,32'h0,32'h0,32'h0,5'd0};
    vecs[12] = '{1'b1,1'b1,1'b1,OP_SLT,5'd9,5'd9,32'h99,32'h99,32'h0,1'b0,5'd9,1'b1, 1'b0,5'd0,32'h0,1'b0,5'd0,32'h0, 1'b0,1'b1,1'b0,1'b0,OP_ADD,32'h0,32'h0,32'h0,5'd0};
    vecs[13] = '{1'b1,1'b1,1'b0,OP_SUB,5'd1,5'd2,32'h10,32'h1,32'h0,1'b0,5'd10,1'b1, 1'b0,5'd0,32'h0,1'b0,5'd0,32'h0, 1'b1,1'b1,1'b1,1'b1,OP_SUB,32'h10,32'h1,32'h1,5'd10};
    vecs[14] = '{1'b1,1'b1,1'b0,OP_AND,5'd1,5'd2,32'h20,32'h2,32'h0,1'b0,5'd11,1'b1, 1'b0,5'd0,32'h0,1'b0,5'd0,32'h0, 1'b1,1'b1,1'b1,1'b1,OP_AND,32'h20,32'h2,32'h2,5'd11};
    vecs[15] = '{1'b1,1'b1,1'b0,OP_OR,5'd1,5'd2,32'h30,32'h3,32'h0,1'b0,5'd12,1'b0, 1'b0,5'd0,32'h0,1'b0,5'd0,32'h0, 1'b1,1'b1,1'b0,1'b1,OP_OR,32'h30,32'h3,32'h3,5'd12};
    vecs[16] = '{1'b1,1'b1,1'b0,OP_SLT,5'd1,5'd2,32'h40,32'hC0,32'hFFFFFFFF,1'b1,5'd13,1'b1, 1'b0,5'd0,32'h0,1'b0,5'd0,32'h0, 1'b1,1'b1,1'b1,1'b1,OP_SLT,32'h40,32'hFFFFFFFF,32'hC0,5'd13};
    vecs[17] = '{1'b0,1'b1,1'b0,OP_ADD,5'd0,5'd0,32'h0,32'h0,32'h0,1'b0,5'd0,1'b0, 1'b0,5'd0,32'h0,1'b0,5'd0,32'h0, 1'b0,1'b1,1'b0,1'b0,OP_ADD,32'h0,32'h0,32'h0,5'd0};

    drive(idle);
    repeat (2) @(negedge clk);
    idle.chk = 1'b1;
    check_vec("reset", idle);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Asynchronous reset in the middle of a cycle while FULL.
    @(negedge clk);
    drive(vecs[0]);
    @(posedge clk);
    #1;
    chk("pre_rst ex_valid", 32'(bus.ex_valid_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst ex_valid",  32'(bus.ex_valid_o),  32'd0);
    chk("async_rst reg_write", 32'(bus.reg_write_o), 32'd0);
    chk("async_rst operand_a", bus.operand_a_o,      32'd0);
    chk("async_rst alu_ctrl",  32'(bus.alu_ctrl_o),  32'(OP_ADD));
    @(negedge clk);
    idle.chk = 1'b0;
    drive(idle);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
